// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Forwarding and load-use hazard control for the 5-stage RISC-V core.
// The block keeps its own shadow copies of the register-usage fields of the
// instructions in ID/EX, EX/MEM and MEM/WB. From these copies it produces the
// select codes for the two EX-stage operand muxes and the load-use stall.
// The operand muxes and the register file live outside this block.
//
// Optional feature: define HAZARD_PERF_EN to add the stall_count and
// fwd_count event counter ports. When the macro is undefined, those ports and
// their logic are absent.
//
// Ports
//   clk          core clock, all state updates on the rising edge
//   reset        asynchronous, active-high, clears all shadow state
//   id_valid     ID stage holds a real instruction
//   id_rs1       rs1 of the instruction in ID
//   id_rs2       rs2 of the instruction in ID
//   id_rd        rd of the instruction in ID
//   id_regwrite  the instruction in ID writes rd
//   id_memread   the instruction in ID is a load
//   flush        taken branch resolved in EX, squash IF/ID and ID/EX
//   forward_a    operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   forward_b    operand B select, same encoding as forward_a
//   stall        hold PC and IF/ID, insert a bubble into ID/EX
//   stall_count  (HAZARD_PERF_EN) number of cycles with stall=1
//   fwd_count    (HAZARD_PERF_EN) number of cycles with any forward active
// -----------------------------------------------------------------------------
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count
`endif
);

    // ID/EX shadow register
    logic [REG_ADDR_W-1:0] idex_rs1;
    logic [REG_ADDR_W-1:0] idex_rs2;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  idex_regwrite;
    logic                  idex_memread;

    // EX/MEM shadow register
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  exmem_regwrite;

    // MEM/WB shadow register
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic                  memwb_regwrite;

    // Per-operand match terms. x0 is hardwired to zero, so a write to it
    // never produces a value that can be forwarded.
    logic exmem_writes;
    logic memwb_writes;
    logic ex_hit_a;
    logic ex_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic load_use;
    logic idex_load;

    assign exmem_writes = exmem_regwrite && (exmem_rd != '0);
    assign memwb_writes = memwb_regwrite && (memwb_rd != '0);

    assign ex_hit_a = exmem_writes && (exmem_rd == idex_rs1);
    assign ex_hit_b = exmem_writes && (exmem_rd == idex_rs2);
    assign wb_hit_a = memwb_writes && (memwb_rd == idex_rs1);
    assign wb_hit_b = memwb_writes && (memwb_rd == idex_rs2);

    // Forward selects depend only on shadow registers, so they are stable for
    // the whole cycle. EX/MEM is checked first because it holds the newer value.
    assign forward_a = ex_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    assign forward_b = ex_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

    // Load in EX whose rd is read by the instruction in ID. Both source fields
    // are compared even if the instruction ignores one; an occasional extra
    // stall is cheaper than decoding operand usage here. A flush squashes the
    // consumer anyway, so there is nothing to wait for.
    assign load_use = idex_memread && (idex_rd != '0) && id_valid &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    assign stall    = load_use && !flush;

    // The ID instruction only enters ID/EX when it is real, not held by a
    // stall and not squashed by a flush; otherwise an all-zero bubble enters.
    assign idex_load = id_valid && !stall && !flush;

    // Shadow pipeline: ID/EX takes the ID fields or a bubble, the later stages
    // always advance one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            if (idex_load) begin
                idex_rs1      <= id_rs1;
                idex_rs2      <= id_rs2;
                idex_rd       <= id_rd;
                idex_regwrite <= id_regwrite;
                idex_memread  <= id_memread;
            end else begin
                idex_rs1      <= '0;
                idex_rs2      <= '0;
                idex_rd       <= '0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
        end
    end

`ifdef HAZARD_PERF_EN
    // Event counters. A cycle forwarding both operands counts once.
    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'd0;
            fwd_count   <= 32'd0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if ((forward_a != 2'b00) || (forward_b != 2'b00)) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
//
// Directed testbench for forward_hazard_unit. The driver applies one
// ID-stage vector per cycle and queues the outputs expected in that cycle,
// which were worked out by hand from the pipeline timeline. The monitor
// samples the outputs on the falling edge and checks them against the queue.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       stall;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] fwd_count;
`endif

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    forward_hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count (stall_count),
        .fwd_count   (fwd_count)
`endif
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drives one ID vector just after a rising edge and queues the outputs
    // expected during that cycle.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic mr,
                                 input logic fl, input logic [1:0] efa, input logic [1:0] efb,
                                 input logic est, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        e.fa = efa;
        e.fb = efb;
        e.st = est;
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.nm, "/fwd_a"}, {30'd0, forward_a}, {30'd0, e.fa});
            checkOutput({e.nm, "/fwd_b"}, {30'd0, forward_b}, {30'd0, e.fb});
            checkOutput({e.nm, "/stall"}, {31'd0, stall}, {31'd0, e.st});
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rd       = '0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        flush       = 1'b0;

        // Reset held, even with a load presented in ID nothing is captured.
        applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 2'b00, 2'b00, 0, "rst0");
        applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 2'b00, 2'b00, 0, "rst1");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "rst2");
        reset = 1'b0;
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "idle0");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "idle1");

        // add x5 ; sub x6,x5,x7 back-to-back -> EX/MEM forward on A
        applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, "b2b_add");
        applyStimulus(1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 2'b00, 2'b00, 0, "b2b_sub");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b10, 2'b00, 0, "b2b_ex");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "b2b_after");

        // add x5 ; non-writing instr ; sub x6,x5,x7 -> MEM/WB forward on A
        applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, "gap_add");
        applyStimulus(1, 5'd3, 5'd4, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "gap_mid");
        applyStimulus(1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 2'b00, 2'b00, 0, "gap_sub");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b00, 0, "gap_ex");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "gap_after");

        // x5 in both EX/MEM and MEM/WB, consumer rs2=x5 -> newest (10) wins
        applyStimulus(1, 5'd1, 5'd1, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, "pri_w1");
        applyStimulus(1, 5'd2, 5'd3, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, "pri_w2");
        applyStimulus(1, 5'd10, 5'd5, 5'd11, 1, 0, 0, 2'b00, 2'b00, 0, "pri_use");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b10, 0, "pri_ex");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "pri_after0");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "pri_after1");

        // lw x8 ; add x9,x8,x8 -> one stall, bubble, then 01/01
        applyStimulus(1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "lu_lw");
        applyStimulus(1, 5'd8, 5'd8, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, "lu_stall");
        applyStimulus(1, 5'd8, 5'd8, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, "lu_bubble");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b01, 0, "lu_ex");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "lu_after");

        // x0 is never forwarded and a load to x0 never stalls
        applyStimulus(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 2'b00, 2'b00, 0, "x0_wr");
        applyStimulus(1, 5'd0, 5'd3, 5'd12, 1, 0, 0, 2'b00, 2'b00, 0, "x0_use");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_ex");
        applyStimulus(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 2'b00, 2'b00, 0, "x0_lw");
        applyStimulus(1, 5'd0, 5'd0, 5'd13, 1, 0, 0, 2'b00, 2'b00, 0, "x0_lwuse");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_after0");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_after1");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_after2");

        // Load-use with flush in the same cycle: no stall, consumer squashed
        applyStimulus(1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "fl_lw");
        applyStimulus(1, 5'd8, 5'd8, 5'd9, 1, 0, 1, 2'b00, 2'b00, 0, "fl_use");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "fl_bubble");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "fl_squashed");

        // Load-use through rs2 only
        applyStimulus(1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "rs2_lw");
        applyStimulus(1, 5'd3, 5'd8, 5'd14, 1, 0, 0, 2'b00, 2'b00, 1, "rs2_stall");
        applyStimulus(1, 5'd3, 5'd8, 5'd14, 1, 0, 0, 2'b00, 2'b00, 0, "rs2_bubble");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b01, 0, "rs2_ex");

        // Matching fields with id_valid=0 never stall
        applyStimulus(1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, "inv_lw");
        applyStimulus(0, 5'd8, 5'd8, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, "inv_use");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "inv_after");
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, "inv_after1");

        // Let the monitor drain the queue, bounded by a cycle budget.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        checkOutput("sb_drain", sb.size(), 32'd0);

`ifdef HAZARD_PERF_EN
        // Forwarding cycles: b2b_ex, gap_ex, pri_ex, lu_ex, rs2_ex.
        // Stall cycles: lu_stall, rs2_stall (the flushed one does not count).
        @(negedge clk);
        checkOutput("stall_count", stall_count, 32'd2);
        checkOutput("fwd_count", fwd_count, 32'd5);
        // Reset clears the counters asynchronously.
        #1;
        reset = 1'b1;
        #1;
        checkOutput("stall_count_rst", stall_count, 32'd0);
        checkOutput("fwd_count_rst", fwd_count, 32'd0);
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
